// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
// Shared types and constants for the NOR flash array model.
//   op_e       : command opcodes carried on cmd_op
//   state_e    : controller states of flash_array_model
//   ERASED_BYTE: value of every byte after erase (and at time 0)
//   RSV_LAT    : cycles a reserved opcode occupies before reporting an error
//   op_state() : maps an accepted opcode to the state that services it
// -----------------------------------------------------------------------------
package flash_pkg;

    typedef enum logic [1:0] {
        FL_READ  = 2'b00,
        FL_PROG  = 2'b01,
        FL_ERASE = 2'b10,
        FL_RSV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_PG   = 3'd2,
        ST_ER   = 3'd3,
        ST_RSV  = 3'd4
    } state_e;

    localparam logic [7:0] ERASED_BYTE = 8'hFF;

    // Reserved opcode sits in ST_RSV for one cycle, then reports done+err.
    localparam int RSV_LAT = 2;

    function automatic state_e op_state(input op_e op);
        case (op)
            FL_READ:  return ST_RD;
            FL_PROG:  return ST_PG;
            FL_ERASE: return ST_ER;
            default:  return ST_RSV;
        endcase
    endfunction

endpackage

// File: rtl/flash_lat_timer.sv
// -----------------------------------------------------------------------------
// flash_lat_timer
// Loadable down-counter that times one flash operation.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears the count)
//   load      : load load_val into the counter
//   load_val  : operation latency in cycles (>= 1)
//   abort     : clear the counter (takes priority over load)
//   expire    : counter == 1, i.e. the final cycle of the operation
//   running   : counter != 0
// -----------------------------------------------------------------------------
module flash_lat_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             abort,
    output logic             expire,
    output logic             running
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire  = (count == CNT_W'(1));
    assign running = (count != '0);

endmodule

// File: rtl/flash_array_model.sv
// -----------------------------------------------------------------------------
// flash_array_model
// Clocked behavioural model of a NOR flash cell array with a
// valid/ready command interface (read line, program byte, erase block).
// Optional feature macro: FLASH_WRITE_PROTECT_EN (adds a block-range write
// protect; protected PROG/ERASE finish with err=1 and leave the array alone).
// Ports:
//   clkm, rst              : array clock, asynchronous active-high reset
//   analog_on              : supply good; low blocks new commands and aborts
//                            an operation in flight (done+err next cycle)
//   cmd_valid/cmd_ready    : command handshake
//   cmd_op/addr/wdata      : opcode (op_e), byte address, program data
//   wp_en, wp_blk_lo/hi    : write-protect enable and block range (macro only)
//   busy                   : operation in flight
//   done, err              : end-of-command pulse and its failure flag
//   rd_valid, rd_data      : read line pulse and data (byte 0 in bits [7:0])
// -----------------------------------------------------------------------------
module flash_array_model
    import flash_pkg::*;
#(
    parameter int PAGE_BYTES    = 256,
    parameter int PAGES         = 16384,
    parameter int PAGES_PER_BLK = 16,
    parameter int LINE_BYTES    = 16,
    parameter int RD_LAT        = 18,
    parameter int PG_LAT        = 40,
    parameter int ER_LAT        = 200,
    localparam int ADDR_W       = $clog2(PAGES * PAGE_BYTES),
    localparam int NUM_BLKS     = PAGES / PAGES_PER_BLK,
    localparam int BLK_W        = (NUM_BLKS > 1) ? $clog2(NUM_BLKS) : 1
) (
    input  logic                    clkm,
    input  logic                    rst,
    input  logic                    analog_on,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [7:0]              cmd_wdata,
`ifdef FLASH_WRITE_PROTECT_EN
    input  logic                    wp_en,
    input  logic [BLK_W-1:0]        wp_blk_lo,
    input  logic [BLK_W-1:0]        wp_blk_hi,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_valid,
    output logic [8*LINE_BYTES-1:0] rd_data
);

    localparam int BLK_BYTES = PAGES_PER_BLK * PAGE_BYTES;
    localparam int OFF_W     = $clog2(BLK_BYTES);
    localparam int MAX_A     = (RD_LAT > PG_LAT) ? RD_LAT : PG_LAT;
    localparam int MAX_B     = (MAX_A > ER_LAT) ? MAX_A : ER_LAT;
    localparam int MAX_LAT   = (MAX_B > RSV_LAT) ? MAX_B : RSV_LAT;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    state_e              state, state_nxt;
    logic                accept;
    logic                abort_q;
    logic                fin;
    logic                pg_commit, er_commit;
    logic                tmr_load, tmr_abort, tmr_expire, tmr_running;
    logic [CNT_W-1:0]    tmr_val;
    logic [ADDR_W-1:0]   op_addr;
    logic [7:0]          op_wdata;
    logic                wp_hit;
    logic [BLK_W-1:0]    op_blk;
    logic [OFF_W-1:0]    op_off, line_base;
    logic [8*LINE_BYTES-1:0] line;

    // Array storage holds each byte XORed with ERASED_BYTE, so a memory that
    // starts out zeroed reads back as fully erased without any initialisation
    // logic. Bytes are grouped per erase block so an erase is one write.
    logic [BLK_BYTES-1:0][7:0] mem_x [NUM_BLKS];

    assign cmd_ready = (state == ST_IDLE) & analog_on & ~rst;
    assign accept    = cmd_valid & cmd_ready;

    flash_lat_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clkm),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .abort    (tmr_abort),
        .expire   (tmr_expire),
        .running  (tmr_running)
    );

    // State register; abort_q carries the done/err pulse of a supply abort.
    always_ff @(posedge clkm or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            abort_q <= (state != ST_IDLE) & ~analog_on;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = op_state(op_e'(cmd_op));
            default: if (!analog_on || tmr_expire) state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        tmr_load  = accept;
        tmr_abort = busy & ~analog_on;
        case (op_e'(cmd_op))
            FL_READ:  tmr_val = CNT_W'(RD_LAT);
            FL_PROG:  tmr_val = CNT_W'(PG_LAT);
            FL_ERASE: tmr_val = CNT_W'(ER_LAT);
            default:  tmr_val = CNT_W'(RSV_LAT);
        endcase
        // A completion in the same cycle the supply drops is an abort instead.
        fin       = busy & tmr_running & tmr_expire & analog_on;
        done      = fin | abort_q;
        err       = abort_q
                  | (fin & (state == ST_RSV))
                  | (fin & wp_hit & ((state == ST_PG) | (state == ST_ER)));
        rd_valid  = fin & (state == ST_RD);
        pg_commit = fin & ~wp_hit & (state == ST_PG);
        er_commit = fin & ~wp_hit & (state == ST_ER);
    end

    always_ff @(posedge clkm) begin
        if (accept) begin
            op_addr  <= cmd_addr;
            op_wdata <= cmd_wdata;
        end
    end

`ifdef FLASH_WRITE_PROTECT_EN
    logic [BLK_W-1:0] cmd_blk;
    assign cmd_blk = BLK_W'(cmd_addr >> OFF_W);

    // Protection is decided from the wp_* inputs seen at accept time.
    always_ff @(posedge clkm) begin
        if (accept) begin
            wp_hit <= wp_en && (cmd_blk >= wp_blk_lo) && (cmd_blk <= wp_blk_hi);
        end
    end
`else
    assign wp_hit = 1'b0;
`endif

    assign op_blk    = BLK_W'(op_addr >> OFF_W);
    assign op_off    = op_addr[OFF_W-1:0];
    assign line_base = op_off & ~OFF_W'(LINE_BYTES - 1);

    // NOR programming can only clear bits: new = old & wdata.
    always_ff @(posedge clkm) begin
        if (pg_commit) begin
            mem_x[op_blk][op_off] <=
                ((mem_x[op_blk][op_off] ^ ERASED_BYTE) & op_wdata) ^ ERASED_BYTE;
        end else if (er_commit) begin
            mem_x[op_blk] <= '0;
        end
    end

    always_comb begin
        line = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            line[8*b +: 8] = mem_x[op_blk][line_base + OFF_W'(b)] ^ ERASED_BYTE;
        end
    end

    assign rd_data = rd_valid ? line : '0;

endmodule

// File: tb/tb_flash_array_model.sv
module tb_flash_array_model;

    localparam int ADDR_W    = 22;
    localparam int LB        = 16;
    localparam int LW        = 8 * LB;
    localparam int RD_LAT    = 18;
    localparam int PG_LAT    = 40;
    localparam int ER_LAT    = 200;
    localparam int BLK_BYTES = 16 * 256;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_PG  = 2'b01;
    localparam logic [1:0] OP_ER  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [LW-1:0] ALLFF   = {LW{1'b1}};
    localparam logic [LW-1:0] L_B3_00 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00FFFFFF;
    localparam logic [LW-1:0] L_B5_00 = 128'hFFFFFFFF_FFFFFFFF_FFFF00FF_FFFFFFFF;
    localparam logic [LW-1:0] L_B0_12 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF12;

    logic              clkm, rst, analog_on, cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              busy, done, err, rd_valid;
    logic [LW-1:0]     rd_data;
`ifdef FLASH_WRITE_PROTECT_EN
    logic              wp_en;
    logic [9:0]        wp_blk_lo, wp_blk_hi;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    flash_array_model #(
        .PAGE_BYTES(256), .PAGES(16384), .PAGES_PER_BLK(16), .LINE_BYTES(LB),
        .RD_LAT(RD_LAT), .PG_LAT(PG_LAT), .ER_LAT(ER_LAT)
    ) dut (
        .clkm      (clkm),
        .rst       (rst),
        .analog_on (analog_on),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
`ifdef FLASH_WRITE_PROTECT_EN
        .wp_en     (wp_en),
        .wp_blk_lo (wp_blk_lo),
        .wp_blk_hi (wp_blk_hi),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    initial clkm = 1'b0;
    always #5 clkm = ~clkm;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference array: sparse byte map, absent entries are erased (0xFF).
    logic [7:0] mdl [int];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mget(input int a);
        return mdl.exists(a) ? mdl[a] : 8'hFF;
    endfunction

    function automatic logic [LW-1:0] mline(input int a);
        logic [LW-1:0] l;
        int base;
        base = a - (a % LB);
        for (int b = 0; b < LB; b++) l[8*b +: 8] = mget(base + b);
        return l;
    endfunction

    task automatic mupd(input logic [1:0] op, input int a, input logic [7:0] wd);
        int base;
        if (op == OP_PG) begin
            mdl[a] = mget(a) & wd;
        end else if (op == OP_ER) begin
            base = a - (a % BLK_BYTES);
            for (int i = 0; i < BLK_BYTES; i++) mdl.delete(base + i);
        end
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            OP_RD:   return RD_LAT;
            OP_PG:   return PG_LAT;
            OP_ER:   return ER_LAT;
            default: return 2;
        endcase
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clkm);
            w++;
        end
        chk("cmd_ready before issue", LW'(cmd_ready), LW'(1));
    endtask

    task automatic start(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [7:0] wd);
        wait_ready();
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clkm);
        #1 cmd_valid = 1'b0;
    endtask

    // Issue one command and compare its completion with the expectations.
    task automatic run(input string nm, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [7:0] wd, input int exp_lat, input logic exp_err,
                       input logic chk_line, input logic [LW-1:0] exp_line);
        int lat;
        logic e, rv, bz;
        logic [LW-1:0] l;
        start(op, a, wd);
        lat = 0; e = 1'b0; rv = 1'b0; bz = 1'b0; l = '0;
        for (int n = 1; n <= ER_LAT + 20; n++) begin
            @(negedge clkm);
            if (done) begin
                lat = n; e = err; rv = rd_valid; bz = busy; l = rd_data;
                break;
            end
        end
        chk({nm, " latency"}, LW'(lat), LW'(exp_lat));
        chk({nm, " err"}, LW'(e), LW'(exp_err));
        chk({nm, " rd_valid"}, LW'(rv), LW'(op == OP_RD && !exp_err));
        chk({nm, " busy at done"}, LW'(bz), LW'(1));
        if (chk_line) chk({nm, " rd_data"}, l, exp_line);
        if (!exp_err) mupd(op, int'(a), wd);
    endtask

    typedef struct {
        string             nm;
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wd;
        int                lat;
        logic              e;
        logic              cl;
        logic [LW-1:0]     line;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [1:0] op;
        logic [ADDR_W-1:0] a;
        logic [7:0] wd;
        int r;

        tbl[0]  = '{"rd_erased",   OP_RD,  22'h000010, 8'h00, RD_LAT, 1'b0, 1'b1, ALLFF};
        tbl[1]  = '{"pg_a5",       OP_PG,  22'h000123, 8'hA5, PG_LAT, 1'b0, 1'b0, '0};
        tbl[2]  = '{"pg_5a",       OP_PG,  22'h000123, 8'h5A, PG_LAT, 1'b0, 1'b0, '0};
        tbl[3]  = '{"rd_and",      OP_RD,  22'h000120, 8'h00, RD_LAT, 1'b0, 1'b1, L_B3_00};
        tbl[4]  = '{"pg_keep",     OP_PG,  22'h002000, 8'h12, PG_LAT, 1'b0, 1'b0, '0};
        tbl[5]  = '{"pg_blk1",     OP_PG,  22'h001005, 8'h00, PG_LAT, 1'b0, 1'b0, '0};
        tbl[6]  = '{"rd_blk1",     OP_RD,  22'h001000, 8'h00, RD_LAT, 1'b0, 1'b1, L_B5_00};
        tbl[7]  = '{"er_blk1",     OP_ER,  22'h001FFF, 8'h00, ER_LAT, 1'b0, 1'b0, '0};
        tbl[8]  = '{"rd_erased1",  OP_RD,  22'h001000, 8'h00, RD_LAT, 1'b0, 1'b1, ALLFF};
        tbl[9]  = '{"rd_kept",     OP_RD,  22'h002000, 8'h00, RD_LAT, 1'b0, 1'b1, L_B0_12};
        tbl[10] = '{"rsv",         OP_RSV, 22'h000000, 8'h00, 2,      1'b1, 1'b0, '0};

        rst = 1'b1; analog_on = 1'b1; cmd_valid = 1'b0;
        cmd_op = OP_RD; cmd_addr = '0; cmd_wdata = '0;
`ifdef FLASH_WRITE_PROTECT_EN
        wp_en = 1'b0; wp_blk_lo = '0; wp_blk_hi = '0;
`endif
        repeat (3) @(negedge clkm);
        chk("reset outputs", LW'({cmd_ready, busy, done, err, rd_valid}), LW'(0));
        chk("reset rd_data", rd_data, '0);
        rst = 1'b0;
        #1 chk("ready after reset", LW'({cmd_ready, busy}), LW'(2'b10));

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].lat, tbl[i].e, tbl[i].cl, tbl[i].line);

        // Supply drop ten cycles into a program of 0x00.
        start(OP_PG, 22'h003000, 8'h00);
        repeat (10) @(negedge clkm);
        chk("no done before abort", LW'(done), LW'(0));
        analog_on = 1'b0;
        @(negedge clkm);
        chk("abort done/err/rdv/busy", LW'({done, err, rd_valid, busy}), LW'(4'b1100));
        cmd_op = OP_RD; cmd_addr = 22'h003000; cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clkm);
            chk("ready/done/busy while supply low", LW'({cmd_ready, done, busy}), LW'(0));
        end
        cmd_valid = 1'b0;
        analog_on = 1'b1;
        #1 chk("ready when supply back", LW'(cmd_ready), LW'(1));
        run("rd_after_abort", OP_RD, 22'h003000, 8'h00, RD_LAT, 1'b0, 1'b1, ALLFF);

        // Reset in the middle of an erase.
        start(OP_ER, 22'h002000, 8'h00);
        repeat (50) @(negedge clkm);
        chk("busy mid erase", LW'(busy), LW'(1));
        rst = 1'b1;
        #1 chk("rst mid-op outputs", LW'({cmd_ready, busy, done, err, rd_valid}), LW'(0));
        chk("rst mid-op rd_data", rd_data, '0);
        @(negedge clkm);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clkm);
            chk("no done after rst", LW'({done, busy}), LW'(0));
        end
        run("rd_after_rst", OP_RD, 22'h002000, 8'h00, RD_LAT, 1'b0, 1'b1, L_B0_12);

`ifdef FLASH_WRITE_PROTECT_EN
        run("pg_wp_setup", OP_PG, 22'h001007, 8'h33, PG_LAT, 1'b0, 1'b0, '0);
        wp_en = 1'b1; wp_blk_lo = 10'd1; wp_blk_hi = 10'd1;
        run("er_protected", OP_ER, 22'h001000, 8'h00, ER_LAT, 1'b1, 1'b0, '0);
        run("pg_protected", OP_PG, 22'h001007, 8'h00, PG_LAT, 1'b1, 1'b0, '0);
        run("rd_protected", OP_RD, 22'h001000, 8'h00, RD_LAT, 1'b0, 1'b1,
            128'hFFFFFFFF_FFFFFFFF_33FFFFFF_FFFFFFFF);
        run("er_unprotected", OP_ER, 22'h002000, 8'h00, ER_LAT, 1'b0, 1'b0, '0);
        run("rd_unprotected", OP_RD, 22'h002000, 8'h00, RD_LAT, 1'b0, 1'b1, ALLFF);
        wp_en = 1'b0;
`endif

        // Randomised commands over three blocks, checked against the byte map.
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 19);
            op = (r < 9) ? OP_RD : (r < 17) ? OP_PG : (r < 18) ? OP_ER : OP_RSV;
            a  = ADDR_W'(($urandom_range(0, 2) << 12) | $urandom_range(0, 63));
            wd = 8'($urandom);
            run("rnd", op, a, wd, lat_of(op), op == OP_RSV, op == OP_RD, mline(int'(a)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
